// File: rtl/fpu_pkg.sv
// Shared types for the FP pipeline tracking stages: fop codes, stage record, div/sqrt FSM state.
package fpu_pkg;

   typedef logic [2:0] fop_t;

   localparam fop_t FOP_ADD  = 3'b000;
   localparam fop_t FOP_SUB  = 3'b001;
   localparam fop_t FOP_MUL  = 3'b010;
   localparam fop_t FOP_DIV  = 3'b100;
   localparam fop_t FOP_SQRT = 3'b110;

   typedef struct packed {
      logic       w;
      logic [4:0] n;
      fop_t       c;
   } stage_t;

   localparam stage_t BUBBLE = '{w: 1'b0, n: 5'd0, c: 3'b000};

   typedef enum logic {IDLE, BUSY} ds_state_t;

   // Any fop with bit 2 set (10x div, 11x sqrt) needs the iterative unit.
   function automatic logic is_div_sqrt(input stage_t s);
      return s.w & s.c[2];
   endfunction

endpackage

// File: rtl/fpu_stage_reg.sv
// One FP pipeline stage record; clear wins over load, otherwise the stage holds.
module fpu_stage_reg
   import fpu_pkg::*;
(
   input  logic   clk,
   input  logic   clear,
   input  logic   load,
   input  stage_t d,
   output stage_t q
);

   always_ff @(posedge clk) begin
      if (clear)
         q <= BUBBLE;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// FP writeback tracking through E1-E3 with multi-cycle fdiv/fsqrt occupancy of E1.
// Optional stall perf counter enabled by defining FPU_PERF_CNT_EN.
module fpu_pipe_ctrl
   import fpu_pkg::*;
#(
   parameter int DIV_LAT  = 16,
   parameter int SQRT_LAT = 16,
   parameter int CNT_W    = 5
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       fc,
   input  logic             wf,
   input  logic [4:0]       fd,
   output logic             e1w,
   output logic             e2w,
   output logic             e3w,
   output logic [4:0]       e1n,
   output logic [4:0]       e2n,
   output logic [4:0]       e3n,
   output logic [2:0]       e1c,
   output logic [2:0]       e2c,
   output logic [2:0]       e3c,
   output logic             stall_div_sqrt,
   output logic             ds_start,
   output logic [CNT_W-1:0] ds_cnt,
   output logic [31:0]      ds_stall_cnt
);

   localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 2);
   localparam logic [CNT_W-1:0] SQRT_INIT = CNT_W'(SQRT_LAT - 2);

   stage_t           id_s, e1_s, e2_s, e3_s;
   ds_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             e1_ds;
   logic [CNT_W-1:0] lat_init;

   assign id_s     = '{w: wf, n: fd, c: fc};
   assign e1_ds    = is_div_sqrt(e1_s);
   assign lat_init = e1_s.c[1] ? SQRT_INIT : DIV_INIT;

   // Stall depends only on state registers, never on the ID inputs.
   always_comb begin
      ds_start       = (state == IDLE) && e1_ds;
      stall_div_sqrt = ds_start || ((state == BUSY) && (cnt != '0));
   end

   // While stalled E1 holds the div/sqrt, E2 gets bubbles and E3 keeps draining.
   fpu_stage_reg u_e1 (.clk(clk), .clear(rst), .load(!stall_div_sqrt), .d(id_s), .q(e1_s));
   fpu_stage_reg u_e2 (.clk(clk), .clear(rst || stall_div_sqrt), .load(1'b1), .d(e1_s), .q(e2_s));
   fpu_stage_reg u_e3 (.clk(clk), .clear(rst), .load(1'b1), .d(e2_s), .q(e3_s));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (e1_ds) begin
                  cnt   <= lat_init;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
               else
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FPU_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst)
         perf_q <= '0;
      else if (stall_div_sqrt)
         perf_q <= perf_q + 32'd1;
   end

   assign ds_stall_cnt = perf_q;
`else
   assign ds_stall_cnt = '0;
`endif

   assign ds_cnt = cnt;
   assign e1w    = e1_s.w;
   assign e1n    = e1_s.n;
   assign e1c    = e1_s.c;
   assign e2w    = e2_s.w;
   assign e2n    = e2_s.n;
   assign e2c    = e2_s.c;
   assign e3w    = e3_s.w;
   assign e3n    = e3_s.n;
   assign e3c    = e3_s.c;

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Directed bench for fpu_pipe_ctrl: pipeline advance table plus div/sqrt stall sequences.
module tb_fpu_pipe_ctrl;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  fc;
   logic        wf;
   logic [4:0]  fd;
   logic        e1w, e2w, e3w;
   logic [4:0]  e1n, e2n, e3n;
   logic [2:0]  e1c, e2c, e3c;
   logic        stall_div_sqrt, ds_start;
   logic [4:0]  ds_cnt;
   logic [31:0] ds_stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   fpu_pipe_ctrl #(.DIV_LAT(16), .SQRT_LAT(4), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .fc(fc), .wf(wf), .fd(fd),
      .e1w(e1w), .e2w(e2w), .e3w(e3w),
      .e1n(e1n), .e2n(e2n), .e3n(e3n),
      .e1c(e1c), .e2c(e2c), .e3c(e3c),
      .stall_div_sqrt(stall_div_sqrt), .ds_start(ds_start),
      .ds_cnt(ds_cnt), .ds_stall_cnt(ds_stall_cnt)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [4:0] n, input logic [2:0] c);
      wf = w;
      fd = n;
      fc = c;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_e1w"}, e1w, 0);  chk({tag, "_e1n"}, e1n, 0);  chk({tag, "_e1c"}, e1c, 0);
      chk({tag, "_e2w"}, e2w, 0);  chk({tag, "_e2n"}, e2n, 0);  chk({tag, "_e2c"}, e2c, 0);
      chk({tag, "_e3w"}, e3w, 0);  chk({tag, "_e3n"}, e3n, 0);  chk({tag, "_e3c"}, e3c, 0);
      chk({tag, "_stall"}, stall_div_sqrt, 0);
      chk({tag, "_start"}, ds_start, 0);
      chk({tag, "_cnt"}, ds_cnt, 0);
   endtask

   task automatic flush();
      drive(1'b0, 5'd0, 3'd0);
      tick(); tick(); tick();
   endtask

   typedef struct {
      logic       wf;
      logic [4:0] fd;
      logic [2:0] fc;
      logic       e1w;
      logic [4:0] e1n;
      logic [2:0] e1c;
      logic       e2w;
      logic [4:0] e2n;
      logic       e3w;
      logic [4:0] e3n;
   } vec_t;

   vec_t vt[7];

   initial begin
      int stalls, stall_a, stall_b, guard, start1, start2;
      logic [31:0] exp_perf;

      vt[0] = '{1'b1, 5'd3,  3'b000, 1'b1, 5'd3,  3'b000, 1'b0, 5'd0,  1'b0, 5'd0};
      vt[1] = '{1'b1, 5'd7,  3'b010, 1'b1, 5'd7,  3'b010, 1'b1, 5'd3,  1'b0, 5'd0};
      vt[2] = '{1'b0, 5'd9,  3'b001, 1'b0, 5'd9,  3'b001, 1'b1, 5'd7,  1'b1, 5'd3};
      vt[3] = '{1'b1, 5'd31, 3'b011, 1'b1, 5'd31, 3'b011, 1'b0, 5'd9,  1'b1, 5'd7};
      vt[4] = '{1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  3'b000, 1'b1, 5'd31, 1'b0, 5'd9};
      vt[5] = '{1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  1'b1, 5'd31};
      vt[6] = '{1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  1'b0, 5'd0};

      // reset for two cycles, then release
      rst = 1'b1;
      drive(1'b0, 5'd0, 3'd0);
      tick(); tick();
      chk_all_zero("rst_hold");
      chk("rst_hold_perf", ds_stall_cnt, 0);
      rst = 1'b0;
      tick();
      chk_all_zero("rst_rel");

      // single fadd f3 walking through the pipe
      drive(1'b1, 5'd3, FOP_ADD);
      tick();
      chk("add_e1w", e1w, 1); chk("add_e1n", e1n, 3);
      drive(1'b0, 5'd0, 3'd0);
      tick();
      chk("add_e2w", e2w, 1); chk("add_e2n", e2n, 3); chk("add_e1w_off", e1w, 0);
      tick();
      chk("add_e3w", e3w, 1); chk("add_e3n", e3n, 3);
      tick();
      chk("add_e3w_off", e3w, 0);

      // back-to-back non-div ops: table driven, no stall ever
      for (int i = 0; i < 7; i++) begin
         drive(vt[i].wf, vt[i].fd, vt[i].fc);
         tick();
         chk($sformatf("tab%0d_e1w", i), e1w, vt[i].e1w);
         chk($sformatf("tab%0d_e1n", i), e1n, vt[i].e1n);
         chk($sformatf("tab%0d_e1c", i), e1c, vt[i].e1c);
         chk($sformatf("tab%0d_e2w", i), e2w, vt[i].e2w);
         chk($sformatf("tab%0d_e2n", i), e2n, vt[i].e2n);
         chk($sformatf("tab%0d_e3w", i), e3w, vt[i].e3w);
         chk($sformatf("tab%0d_e3n", i), e3n, vt[i].e3n);
         chk($sformatf("tab%0d_stall", i), stall_div_sqrt, 0);
      end

      // fdiv f5 with fadd f6 waiting at ID
      drive(1'b1, 5'd5, FOP_DIV);
      tick();
      drive(1'b1, 5'd6, FOP_ADD);
      stalls = 0;
      for (int c = 1; c <= 16; c++) begin
         chk($sformatf("div_c%0d_e1w", c), e1w, 1);
         chk($sformatf("div_c%0d_e1n", c), e1n, 5);
         chk($sformatf("div_c%0d_stall", c), stall_div_sqrt, (c <= 15));
         chk($sformatf("div_c%0d_start", c), ds_start, (c == 1));
         if (c >= 2) begin
            chk($sformatf("div_c%0d_cnt", c), ds_cnt, 16 - c);
            chk($sformatf("div_c%0d_e2w", c), e2w, 0);
         end
         if (stall_div_sqrt) stalls++;
         tick();
      end
      chk("div_stall_total", stalls, 15);
      chk("div_c17_e1n", e1n, 6);
      chk("div_c17_e1c", e1c, FOP_ADD);
      chk("div_c17_e2w", e2w, 1);
      chk("div_c17_e2n", e2n, 5);
      chk("div_c17_e2c", e2c, FOP_DIV);
      chk("div_c17_stall", stall_div_sqrt, 0);
      flush();

      // fmul f2 drains past an fdiv f4
      drive(1'b1, 5'd2, FOP_MUL);
      tick();
      chk("drain_mul_e1n", e1n, 2);
      drive(1'b1, 5'd4, FOP_DIV);
      tick();
      chk("drain_e1n", e1n, 4); chk("drain_e2n", e2n, 2); chk("drain_e2w", e2w, 1);
      chk("drain_stall", stall_div_sqrt, 1);
      drive(1'b0, 5'd0, 3'd0);
      tick();
      chk("drain_e2w_bub", e2w, 0); chk("drain_e2n_bub", e2n, 0);
      chk("drain_e3w", e3w, 1); chk("drain_e3n", e3n, 2); chk("drain_e3c", e3c, FOP_MUL);
      tick();
      chk("drain_e3w_off", e3w, 0); chk("drain_e3n_off", e3n, 0); chk("drain_e2w_bub2", e2w, 0);
      guard = 0;
      while (stall_div_sqrt && guard < 40) begin
         tick();
         guard++;
      end
      chk("drain_stall_bound", (guard < 40), 1);
      chk("drain_exit_e1n", e1n, 4);
      tick();
      chk("drain_div_e2w", e2w, 1); chk("drain_div_e2n", e2n, 4); chk("drain_div_e2c", e2c, FOP_DIV);
      flush();

      // fsqrt f1 (4 cycles) immediately followed by fdiv f8 (16 cycles)
      drive(1'b1, 5'd1, FOP_SQRT);
      tick();
      drive(1'b1, 5'd8, FOP_DIV);
      stall_a = 0; stall_b = 0; start1 = 0; start2 = 0;
      for (int c = 1; c <= 20; c++) begin
         chk($sformatf("sd_c%0d_e1w", c), e1w, 1);
         chk($sformatf("sd_c%0d_e1n", c), e1n, (c <= 4) ? 1 : 8);
         chk($sformatf("sd_c%0d_stall", c), stall_div_sqrt, (c <= 3) || (c >= 5 && c <= 19));
         chk($sformatf("sd_c%0d_start", c), ds_start, (c == 1) || (c == 5));
         if (stall_div_sqrt) begin
            if (c <= 4) stall_a++; else stall_b++;
         end
         if (ds_start) begin
            if (start1 == 0) start1 = c; else start2 = c;
         end
         if (c == 5) drive(1'b0, 5'd0, 3'd0);
         tick();
      end
      chk("sd_stall_sqrt", stall_a, 3);
      chk("sd_stall_div", stall_b, 15);
      chk("sd_start_gap", start2 - start1, 4);
      chk("sd_c21_e1w", e1w, 0);
      chk("sd_c21_e2n", e2n, 8);
      flush();

      // reset on the 5th stall cycle of an fdiv
      drive(1'b1, 5'd5, FOP_DIV);
      tick();
      drive(1'b0, 5'd0, 3'd0);
      tick(); tick(); tick(); tick();
      chk("rstmid_stall_c5", stall_div_sqrt, 1);
      chk("rstmid_cnt_c5", ds_cnt, 11);
      rst = 1'b1;
      tick();
      chk_all_zero("rstmid");
      chk("rstmid_perf", ds_stall_cnt, 0);
      rst = 1'b0;
      tick();
      chk("rstmid_after_stall", stall_div_sqrt, 0);
      chk("rstmid_after_start", ds_start, 0);
      chk("rstmid_after_e1w", e1w, 0);

      // one clean fdiv for the perf counter
`ifdef FPU_PERF_CNT_EN
      exp_perf = 32'd15;
`else
      exp_perf = 32'd0;
`endif
      drive(1'b1, 5'd9, FOP_DIV);
      tick();
      drive(1'b0, 5'd0, 3'd0);
      guard = 0;
      while (stall_div_sqrt && guard < 40) begin
         tick();
         guard++;
      end
      chk("perf_stall_bound", (guard < 40), 1);
      chk("perf_cnt", ds_stall_cnt, exp_perf);
      flush();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
